// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1-to-4 stream demultiplexer.
package demux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int NUM_OUT = 4;
    localparam int ADDR_W  = 2;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding register. A load wins over a drain, so a slot
// drained and refilled in the same cycle stays valid with the new beat.
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             empty
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    assign empty = !valid;

endmodule

// File: rtl/stream_demux4.sv
// One upstream stream fanned out to four sinks; multi-beat packets stay
// locked to one destination until their last beat.
//   state  | meaning
//   IDLE   | no packet open; beats routed by address
//   LOCKED | packet open; beats routed by sel, address ignored
module stream_demux4
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    input  logic [ADDR_W-1:0]        address,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_last,
    output logic                     busy,
    output logic [ADDR_W-1:0]        sel
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   sel_q, sel_nxt;
    logic [ADDR_W-1:0]   target;
    logic [NUM_OUT-1:0]  slot_empty;
    logic [NUM_OUT-1:0]  load;
    logic                accept;

    assign target   = (state == IDLE) ? address : sel_q;
    assign in_ready = slot_empty[target] | out_ready[target];
    assign accept   = in_valid & in_ready;

    always_comb begin
        load = '0;
        if (accept) load[target] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= '0;
        end else begin
            state <= state_nxt;
            sel_q <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    sel_nxt = address;
                    if (!in_last) state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && in_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == LOCKED);
    assign sel  = sel_q;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_out_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .drain     (out_ready[k]),
            .load_data (in_data),
            .load_last (in_last),
            .valid     (out_valid[k]),
            .data      (out_data[k*WIDTH +: WIDTH]),
            .last      (out_last[k]),
            .empty     (slot_empty[k])
        );
    end

endmodule
